// File: rtl/cpu_isa_pkg.sv
// ISA constants, fetch-FSM state encoding and opcode helpers shared by the 8-bit CPU front end.
package cpu_isa_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADN = 4'h7;
  localparam logic [3:0] OP_INC = 4'h8;
  localparam logic [3:0] OP_DEC = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_OPER   = 3'd2,
    S_ISSUE  = 3'd3,
    S_HALT   = 3'd4
  } fetch_state_e;

  // Opcodes whose second byte is an operand consumed inside fetch.
  function automatic logic is_two_byte(input logic [3:0] op);
    return op == OP_JMP;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: PC/IR owner, resolves JMP and HLT locally; 3 cycles per issued instruction.
// Issue holds op/arg/pc stable under instr_ready=0 and performs no ROM access until the handshake.
module instr_fetch
  import cpu_isa_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter bit                SKIP_NOP = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_read,
  output logic              rom_ena,
  input  logic [DATA_W-1:0] rom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [3:0]        instr_op,
  output logic [3:0]        instr_arg,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [3:0]        op;

  assign op = ir_q[DATA_W-1 -: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ipc_q   <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        ir_d    = rom_data;
        ipc_d   = pc_q;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_two_byte(op))                state_d = S_OPER;
        else if (op == OP_HLT)              state_d = S_HALT;
        else if (SKIP_NOP && op == OP_NOP)  state_d = S_FETCH;
        else                                state_d = S_ISSUE;
      end
      S_OPER: begin
        // Operand byte is the absolute jump target; the JMP's own low nibble is unused.
        pc_d    = rom_data[ADDR_W-1:0];
        state_d = S_FETCH;
      end
      S_ISSUE: begin
        if (instr_ready) state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Gating with rst_n drops the strobes as soon as reset asserts, not at the next edge.
  assign rom_read    = rst_n && (state_q == S_FETCH || state_q == S_OPER);
  assign rom_ena     = rom_read;
  assign rom_addr    = pc_q;
  assign instr_valid = (state_q == S_ISSUE);
  assign instr_op    = op;
  assign instr_arg   = ir_q[3:0];
  assign instr_pc    = ipc_q;
  assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench: dut 0 (reset PC 0x00, NOPs issued), dut 1 (reset PC 0xFF, NOPs skipped).
module tb_instr_fetch;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] arg;
    logic [7:0] pc;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] rom [256];
  logic [7:0] addr_a [2];
  logic [7:0] pc_a   [2];
  logic [3:0] op_a   [2];
  logic [3:0] arg_a  [2];
  logic       rd_a   [2];
  logic       en_a   [2];
  logic       vld_a  [2];
  logic       hlt_a  [2];
  logic       rdy       [2] = '{1'b1, 1'b1};
  logic       force_rdy [2] = '{1'b1, 1'b1};
  bit         rand_rdy = 1'b0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;

  exp_t exp_q [2][$];
  bit   exp_more [2];
  bit   exp_halt [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++)
      rdy[i] = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy[i];
  end

  task automatic check(input bit ok, input string nm, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, req, cyc);
  endtask

  // Reference: walk the program as an instruction stream and list what must be issued.
  task automatic build_exp(input int g, input logic [7:0] start, input bit skip);
    logic [7:0] pc, b, nxt;
    int steps;
    pc = start;
    steps = 0;
    exp_q[g].delete();
    exp_more[g] = 1'b1;
    exp_halt[g] = 1'b0;
    while (steps < 400 && exp_q[g].size() < 25) begin
      b = rom[pc];
      nxt = pc + 8'd1;
      steps++;
      if (b[7:4] == 4'hA) pc = rom[nxt];
      else if (b[7:4] == 4'hF) begin
        exp_more[g] = 1'b0;
        exp_halt[g] = 1'b1;
        break;
      end else begin
        if (!(skip && b[7:4] == 4'h0)) exp_q[g].push_back(exp_t'({b[7:4], b[3:0], pc}));
        pc = nxt;
      end
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wire [7:0] rdat;
    assign rdat = (rd_a[g] && en_a[g]) ? rom[addr_a[g]] : 8'hzz;

    instr_fetch #(
      .ADDR_W(8), .DATA_W(8),
      .RESET_PC((g == 0) ? 8'h00 : 8'hFF),
      .SKIP_NOP(g == 1)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .rom_addr(addr_a[g]), .rom_read(rd_a[g]), .rom_ena(en_a[g]), .rom_data(rdat),
      .instr_valid(vld_a[g]), .instr_ready(rdy[g]),
      .instr_op(op_a[g]), .instr_arg(arg_a[g]), .instr_pc(pc_a[g]),
      .halted(hlt_a[g])
    );

    int         last_cyc;
    logic [7:0] last_pc, pend_addr;
    bit         have_last, rdy_run, pend, prev_stall;
    exp_t       prev, got, e;

    always @(negedge clk) begin
      if (!rst_n) begin
        pend = 1'b0;
        prev_stall = 1'b0;
        have_last = 1'b0;
        rdy_run = 1'b1;
      end else begin
        got = {op_a[g], arg_a[g], pc_a[g]};
        if (pend) begin
          check(rd_a[g] && en_a[g] && addr_a[g] == pend_addr, "next_fetch", 16'(addr_a[g]), 16'(pend_addr));
          pend = 1'b0;
        end
        if (prev_stall) check(vld_a[g] && got == prev, "stall_hold", got, prev);
        if (vld_a[g]) check(!rd_a[g] && !en_a[g], "no_rom_in_issue", 16'(rd_a[g]), 16'h0);
        if (!rdy[g]) rdy_run = 1'b0;
        if (vld_a[g] && rdy[g]) begin
          if (exp_q[g].size() > 0) begin
            e = exp_q[g].pop_front();
            check(got == e, "issue", got, e);
          end else if (!exp_more[g]) begin
            check(1'b0, "extra_issue", got, 16'h0);
          end
          if (have_last && rdy_run && pc_a[g] == last_pc + 8'd1)
            check(cyc - last_cyc == 3, "issue_spacing", 16'(cyc - last_cyc), 16'd3);
          have_last = 1'b1;
          last_pc = pc_a[g];
          last_cyc = cyc;
          rdy_run = 1'b1;
          pend = 1'b1;
          pend_addr = pc_a[g] + 8'd1;
        end
        prev_stall = vld_a[g] && !rdy[g];
        prev = got;
      end
    end
  end

  function automatic bit done(input int g);
    return exp_q[g].size() == 0 && (!exp_halt[g] || hlt_a[g]);
  endfunction

  task automatic wait_fetch(input int g, input logic [7:0] a, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rd_a[g] && addr_a[g] == a) && n < 300);
    check(rd_a[g] && addr_a[g] == a, nm, 16'(addr_a[g]), 16'(a));
  endtask

  task automatic load_std();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h01] = 8'h81; rom[8'h02] = 8'h81; rom[8'h03] = 8'h81;
    rom[8'h04] = 8'h91; rom[8'h05] = 8'h73; rom[8'h06] = 8'h81;
    rom[8'h07] = 8'hA3; rom[8'h08] = 8'h0F; rom[8'h0F] = 8'h81;
    rom[8'h10] = 8'hF0; rom[8'hFF] = 8'h81;
  endtask

  task automatic run_prog(input int budget);
    int n;
    n = 0;
    rst_n = 1'b0;
    build_exp(0, 8'h00, 1'b0);
    build_exp(1, 8'hFF, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    while (n < budget && !(done(0) && done(1))) begin
      @(negedge clk);
      n++;
    end
    check(done(0), "run_complete0", 16'(exp_q[0].size()), 16'h0);
    check(done(1), "run_complete1", 16'(exp_q[1].size()), 16'h0);
  endtask

  initial begin
    int stall, bad;
    logic [3:0] op;
    int r;
    load_std();
    #1 rst_n = 1'b0;
    build_exp(0, 8'h00, 1'b0);
    build_exp(1, 8'hFF, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check(addr_a[0] == 8'h00, "reset_addr0", 16'(addr_a[0]), 16'h00);
      check(!rd_a[0] && !en_a[0], "reset_strobes0", 16'({rd_a[0], en_a[0]}), 16'h0);
      check(!vld_a[0] && !hlt_a[0], "reset_vld_hlt0", 16'({vld_a[0], hlt_a[0]}), 16'h0);
      check(addr_a[1] == 8'hFF && !rd_a[1], "reset_addr1", 16'(addr_a[1]), 16'hFF);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    wait_fetch(0, 8'h02, "fetch_02");
    force_rdy[0] = 1'b0;
    stall = 0;
    repeat (7) begin
      @(negedge clk);
      if (vld_a[0] && !rdy[0]) stall++;
    end
    check(stall >= 5, "stall_cycles", 16'(stall), 16'd5);
    force_rdy[0] = 1'b1;

    wait_fetch(0, 8'h07, "fetch_jmp");
    @(negedge clk);
    check(!rd_a[0], "jmp_decode_quiet", 16'(rd_a[0]), 16'h0);
    @(negedge clk);
    check(rd_a[0] && addr_a[0] == 8'h08, "jmp_oper", 16'(addr_a[0]), 16'h08);
    @(negedge clk);
    check(rd_a[0] && addr_a[0] == 8'h0F, "jmp_target", 16'(addr_a[0]), 16'h0F);

    wait_fetch(0, 8'h10, "fetch_hlt");
    @(negedge clk);
    check(!hlt_a[0], "halt_not_early", 16'(hlt_a[0]), 16'h0);
    @(negedge clk);
    check(hlt_a[0], "halt_latency", 16'(hlt_a[0]), 16'h1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (rd_a[0] || en_a[0] || vld_a[0] || !hlt_a[0]) bad++;
    end
    check(bad == 0, "halt_absorbing", 16'(bad), 16'h0);
    check(exp_q[0].size() == 0, "all_issued0", 16'(exp_q[0].size()), 16'h0);
    for (int i = 0; i < 200 && !hlt_a[1]; i++) @(negedge clk);
    check(hlt_a[1], "halt1", 16'(hlt_a[1]), 16'h1);
    check(exp_q[1].size() == 0, "all_issued1", 16'(exp_q[1].size()), 16'h0);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check(!hlt_a[0] && !hlt_a[1], "reset_clears_halt", 16'({hlt_a[0], hlt_a[1]}), 16'h0);
    build_exp(0, 8'h00, 1'b0);
    build_exp(1, 8'hFF, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check(rd_a[0] && addr_a[0] == 8'h00, "restart_fetch", 16'(addr_a[0]), 16'h00);

    wait_fetch(0, 8'h08, "reach_oper");
    #2 rst_n = 1'b0;
    #1;
    check(!rd_a[0] && !en_a[0], "abort_strobes", 16'({rd_a[0], en_a[0]}), 16'h0);
    check(addr_a[0] == 8'h00, "abort_pc0", 16'(addr_a[0]), 16'h00);
    check(!rd_a[1] && addr_a[1] == 8'hFF, "abort_pc1", 16'(addr_a[1]), 16'hFF);
    build_exp(0, 8'h00, 1'b0);
    build_exp(1, 8'hFF, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check(rd_a[0] && addr_a[0] == 8'h00, "post_abort_fetch", 16'(addr_a[0]), 16'h00);

    rand_rdy = 1'b1;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 256; i++) begin
        r = $urandom_range(0, 99);
        if (r < 8) op = 4'hA;
        else if (r < 10) op = 4'hF;
        else begin
          op = 4'($urandom_range(0, 13));
          if (op == 4'hA) op = 4'hE;
        end
        rom[i] = {op, 4'($urandom_range(0, 15))};
      end
      run_prog(4000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
